// File: rtl/rm_lane_release_if.sv
// Lane-release tracker bus: allocator grant and commit activity in, per-slot
// lane release events, busy map and dropped-grant count out.
interface rm_lane_release_if #(
    parameter int NUM_LANES  = 4,
    parameter int NUM_EVENTS = 10,
    parameter int NR_COMMIT  = 2,
    parameter int VLEN       = 32
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                            flush_i;
    logic                            monitor_ins_i;
    logic [LW-1:0]                   monitor_lane_i;
    logic [VLEN-1:0]                 monitor_pc_i;
    logic [NR_COMMIT-1:0]            commit_valid_i;
    logic [NR_COMMIT-1:0][VLEN-1:0]  commit_pc_i;
    // lane_ctrl per slot: reset_lane flag plus the lane index it frees
    logic [NUM_EVENTS-1:0]           reset_lane_o;
    logic [NUM_EVENTS-1:0][LW-1:0]   reset_lane_idx_o;
    logic [NUM_LANES-1:0]            lane_busy_o;
    logic [15:0]                     overflow_cnt_o;

    modport master (
        output flush_i, monitor_ins_i, monitor_lane_i, monitor_pc_i,
               commit_valid_i, commit_pc_i,
        input  reset_lane_o, reset_lane_idx_o, lane_busy_o, overflow_cnt_o
    );

    modport slave (
        input  flush_i, monitor_ins_i, monitor_lane_i, monitor_pc_i,
               commit_valid_i, commit_pc_i,
        output reset_lane_o, reset_lane_idx_o, lane_busy_o, overflow_cnt_o
    );
endinterface

// File: rtl/rm_lane_release.sv
// Per-lane lifetime tracker for the runtime-monitor lane pool: one FSM per lane
// (FREE -> PENDING -> ACTIVE -> RELEASE) driving the lane release event slots.
module rm_lane_release #(
    parameter int NUM_LANES    = 4,
    parameter int NUM_EVENTS   = 10,
    parameter int NR_COMMIT    = 2,
    parameter int WINDOW       = 8,
    parameter int PEND_TIMEOUT = 64,
    parameter int VLEN         = 32
) (
    input logic              clk_i,
    input logic              rst_ni,
    rm_lane_release_if.slave bus
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {FREE, PENDING, ACTIVE, RELEASE} lane_state_e;

    lane_state_e                   lane_state [NUM_LANES];
    logic [15:0]                   lane_cnt   [NUM_LANES];
    logic [VLEN-1:0]               lane_pc    [NUM_LANES];
    logic [15:0]                   overflow_cnt;

    logic                          grant_acc;
    logic                          drop;
    logic                          port_taken;
    logic [NUM_LANES-1:0]          take;
    logic [NUM_LANES-1:0]          commit_hit;
    logic [NUM_LANES-1:0]          slot_gnt;
    logic [NUM_LANES-1:0]          busy;
    logic [NUM_EVENTS-1:0]         ev_vld;
    logic [NUM_EVENTS-1:0][LW-1:0] ev_lane;
    int                            n_rel;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A grant only lands on a FREE lane or one being released this very edge.
    always_comb begin
        grant_acc = bus.monitor_ins_i && !bus.flush_i;
        take      = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            take[l] = grant_acc && (bus.monitor_lane_i == LW'(l)) &&
                      (lane_state[l] == FREE || lane_state[l] == RELEASE);
        end
        drop = grant_acc && (take == '0);
    end

    always_comb begin
        commit_hit = '0;
        port_taken = 1'b0;
        for (int p = 0; p < NR_COMMIT; p++) begin
            port_taken = 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (!port_taken && bus.commit_valid_i[p] && lane_state[l] == PENDING &&
                    lane_pc[l] == bus.commit_pc_i[p]) begin
                    commit_hit[l] = 1'b1;
                    port_taken    = 1'b1;
                end
            end
        end
    end

    // Release requesters fill event slots in ascending lane order; the rest wait.
    always_comb begin
        ev_vld   = '0;
        ev_lane  = '0;
        slot_gnt = '0;
        busy     = '0;
        n_rel    = 0;
        for (int l = 0; l < NUM_LANES; l++) begin
            busy[l] = (lane_state[l] != FREE);
            if (lane_state[l] == RELEASE) begin
                for (int s = 0; s < NUM_EVENTS; s++) begin
                    if (s == n_rel) begin
                        ev_vld[s]  = 1'b1;
                        ev_lane[s] = LW'(l);
                    end
                end
                slot_gnt[l] = (n_rel < NUM_EVENTS);
                n_rel       = n_rel + 1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                lane_state[l] <= FREE;
                lane_cnt[l]   <= '0;
            end
            overflow_cnt <= '0;
        end else begin
            if (drop) overflow_cnt <= sat_inc(overflow_cnt);
            for (int l = 0; l < NUM_LANES; l++) begin
                case (lane_state[l])
                    FREE: begin
                        if (take[l]) begin
                            lane_state[l] <= PENDING;
                            lane_cnt[l]   <= 16'(PEND_TIMEOUT - 1);
                        end
                    end
                    PENDING: begin
                        if (bus.flush_i) begin
                            lane_state[l] <= RELEASE;
                        end else if (commit_hit[l]) begin
                            lane_state[l] <= ACTIVE;
                            lane_cnt[l]   <= 16'(WINDOW - 1);
                        end else if (lane_cnt[l] == '0) begin
                            lane_state[l] <= RELEASE;
                        end else begin
                            lane_cnt[l] <= lane_cnt[l] - 16'd1;
                        end
                    end
                    ACTIVE: begin
                        if (lane_cnt[l] == '0) lane_state[l] <= RELEASE;
                        else                   lane_cnt[l]   <= lane_cnt[l] - 16'd1;
                    end
                    RELEASE: begin
                        if (take[l]) begin
                            lane_state[l] <= PENDING;
                            lane_cnt[l]   <= 16'(PEND_TIMEOUT - 1);
                        end else if (slot_gnt[l]) begin
                            lane_state[l] <= FREE;
                        end
                    end
                    default: lane_state[l] <= FREE;
                endcase
            end
        end
    end

    // Stored PC is data only; its value matters solely while the lane is PENDING.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (take[l]) lane_pc[l] <= bus.monitor_pc_i;
        end
    end

    assign bus.reset_lane_o     = ev_vld;
    assign bus.reset_lane_idx_o = ev_lane;
    assign bus.lane_busy_o      = busy;
    assign bus.overflow_cnt_o   = overflow_cnt;
endmodule

// File: tb/tb_rm_lane_release.sv
// Bench for rm_lane_release: two instances (10 and 2 event slots) share stimulus.
module tb_rm_lane_release;
    localparam int T  = 64;
    localparam int W  = 8;
    localparam int MF = 0, MP = 1, MA = 2, MR = 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             ins, flush;
    logic [1:0]       lane;
    logic [31:0]      pc;
    logic [1:0]       cv;
    logic [1:0][31:0] cpc;
    int               ncmp = 0, nerr = 0;
    int               n;
    bit               got;

    always #5 clk = ~clk;

    rm_lane_release_if #(.NUM_LANES(4), .NUM_EVENTS(10), .NR_COMMIT(2), .VLEN(32)) ifa ();
    rm_lane_release_if #(.NUM_LANES(4), .NUM_EVENTS(2),  .NR_COMMIT(2), .VLEN(32)) ifb ();

    assign ifa.flush_i = flush;  assign ifa.monitor_ins_i = ins;  assign ifa.monitor_lane_i = lane;
    assign ifa.monitor_pc_i = pc;  assign ifa.commit_valid_i = cv;  assign ifa.commit_pc_i = cpc;
    assign ifb.flush_i = flush;  assign ifb.monitor_ins_i = ins;  assign ifb.monitor_lane_i = lane;
    assign ifb.monitor_pc_i = pc;  assign ifb.commit_valid_i = cv;  assign ifb.commit_pc_i = cpc;

    rm_lane_release #(.NUM_LANES(4), .NUM_EVENTS(10), .NR_COMMIT(2), .WINDOW(W),
                      .PEND_TIMEOUT(T), .VLEN(32)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
    rm_lane_release #(.NUM_LANES(4), .NUM_EVENTS(2), .NR_COMMIT(2), .WINDOW(W),
                      .PEND_TIMEOUT(T), .VLEN(32)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

    // Reference model: lane phase plus the absolute cycle at which it times out.
    int          mode [2][4];
    int          dl   [2][4];
    logic [31:0] mpc  [2][4];
    int          movf [2];
    int          cyc = 0;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            movf[m] = 0;
            for (int l = 0; l < 4; l++) begin mode[m][l] = MF; dl[m][l] = 0; mpc[m][l] = '0; end
        end
    endtask

    task automatic model_step(input int m);
        int ne, used;
        bit acc, g, found;
        bit freed [4];
        bit hit [4];
        ne = (m == 0) ? 10 : 2;
        used = 0;
        for (int l = 0; l < 4; l++) begin freed[l] = 0; hit[l] = 0; end
        for (int l = 0; l < 4; l++)
            if (mode[m][l] == MR && used < ne) begin freed[l] = 1; used++; end
        for (int p = 0; p < 2; p++) begin
            found = 0;
            for (int l = 0; l < 4; l++)
                if (cv[p] && !found && mode[m][l] == MP && mpc[m][l] == cpc[p]) begin
                    hit[l] = 1; found = 1;
                end
        end
        acc = ins && !flush;
        if (acc && mode[m][int'(lane)] != MF && mode[m][int'(lane)] != MR && movf[m] < 65535)
            movf[m]++;
        for (int l = 0; l < 4; l++) begin
            g = acc && (int'(lane) == l);
            case (mode[m][l])
                MF: if (g) begin mode[m][l] = MP; dl[m][l] = cyc + T; mpc[m][l] = pc; end
                MP: begin
                    if (flush)                 mode[m][l] = MR;
                    else if (hit[l])           begin mode[m][l] = MA; dl[m][l] = cyc + W; end
                    else if (cyc == dl[m][l])  mode[m][l] = MR;
                end
                MA: if (cyc == dl[m][l]) mode[m][l] = MR;
                default: begin
                    if (g)             begin mode[m][l] = MP; dl[m][l] = cyc + T; mpc[m][l] = pc; end
                    else if (freed[l]) mode[m][l] = MF;
                end
            endcase
        end
    endtask

    task automatic model_out(input int m, output logic [9:0] ev, output logic [9:0][1:0] ix,
                             output logic [3:0] bz);
        int ne, used;
        ne = (m == 0) ? 10 : 2;
        used = 0; ev = '0; ix = '0; bz = '0;
        for (int l = 0; l < 4; l++) begin
            bz[l] = (mode[m][l] != MF);
            if (mode[m][l] == MR && used < ne) begin
                ev[used] = 1'b1; ix[used] = 2'(l); used++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle();
        ins = 0; flush = 0; lane = '0; pc = '0; cv = '0; cpc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin model_step(0); model_step(1); end
        cyc++;
        #1;
    endtask

    task automatic cmp_model();
        logic [9:0] ev; logic [9:0][1:0] ix; logic [3:0] bz;
        model_out(0, ev, ix, bz);
        chk("a_events", 64'(ifa.reset_lane_o), 64'(ev));
        chk("a_idx",    64'(ifa.reset_lane_idx_o), 64'(ix));
        chk("a_busy",   64'(ifa.lane_busy_o), 64'(bz));
        chk("a_ovf",    64'(ifa.overflow_cnt_o), 64'(movf[0]));
        model_out(1, ev, ix, bz);
        chk("b_events", 64'(ifb.reset_lane_o), 64'(ev[1:0]));
        chk("b_idx",    64'(ifb.reset_lane_idx_o), 64'(ix[1:0]));
        chk("b_busy",   64'(ifb.lane_busy_o), 64'(bz));
        chk("b_ovf",    64'(ifb.overflow_cnt_o), 64'(movf[1]));
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_busy", 64'(ifa.lane_busy_o), 64'd0);
        chk("rst_a_ovf",  64'(ifa.overflow_cnt_o), 64'd0);
        chk("rst_a_ev",   64'(ifa.reset_lane_o), 64'd0);
        chk("rst_b_busy", 64'(ifb.lane_busy_o), 64'd0);
        chk("rst_b_ev",   64'(ifb.reset_lane_o), 64'd0);
        rst_n = 1;
    endtask

    typedef struct {
        logic        ins;
        logic [1:0]  lane;
        logic [31:0] pc;
        logic        flush;
        logic [1:0]  cv;
        logic [31:0] cpc;
        logic [3:0]  busy;
        logic [15:0] ovf;
        int          nev;
        logic [1:0]  lane0;
    } vec_t;

    function automatic vec_t mk(int i, int ln, int p, int fl, int c, int cp,
                                int bz, int ov, int nev, int l0);
        vec_t v;
        v.ins = 1'(i); v.lane = 2'(ln); v.pc = 32'(p); v.flush = 1'(fl);
        v.cv = 2'(c); v.cpc = 32'(cp); v.busy = 4'(bz); v.ovf = 16'(ov);
        v.nev = nev; v.lane0 = 2'(l0);
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              ins ln  pc     fl cv cpc    busy ovf nev l0
        tbl[0]  = mk(1, 0, 'h80, 0, 0, 0,     1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,    0, 1, 'h80,  1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 'h44, 0, 0, 0,     1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0,    1, 0, 0,     1, 1, 0, 0);
        for (int i = 4; i <= 8; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0,    0, 0, 0,     1, 1, 1, 0);
        tbl[10] = mk(0, 0, 0,    0, 0, 0,     0, 1, 0, 0);
        tbl[11] = mk(1, 1, 'h10, 0, 1, 'h10,  2, 1, 0, 0);
        tbl[12] = mk(0, 0, 0,    0, 2, 'h10,  2, 1, 0, 0);
        tbl[13] = mk(1, 1, 'h20, 1, 0, 0,     2, 1, 0, 0);
        tbl[14] = mk(1, 2, 'h10, 0, 3, 'h10,  6, 1, 0, 0);
        tbl[15] = mk(0, 0, 0,    0, 1, 'h10,  6, 1, 0, 0);

        idle();
        model_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ins = tbl[i].ins; lane = tbl[i].lane; pc = tbl[i].pc; flush = tbl[i].flush;
            cv = tbl[i].cv; cpc[0] = tbl[i].cpc; cpc[1] = tbl[i].cpc;
            tick();
            chk("tbl_a_busy", 64'(ifa.lane_busy_o), 64'(tbl[i].busy));
            chk("tbl_a_ovf",  64'(ifa.overflow_cnt_o), 64'(tbl[i].ovf));
            chk("tbl_a_ev",   64'(ifa.reset_lane_o), 64'((1 << tbl[i].nev) - 1));
            chk("tbl_b_busy", 64'(ifb.lane_busy_o), 64'(tbl[i].busy));
            chk("tbl_b_ev",   64'(ifb.reset_lane_o), 64'((1 << tbl[i].nev) - 1));
            if (tbl[i].nev > 0)
                chk("tbl_a_lane0", 64'(ifa.reset_lane_idx_o[0]), 64'(tbl[i].lane0));
        end

        // Pending timeout: event exactly PEND_TIMEOUT cycles after the grant.
        do_reset();
        ins = 1; lane = 2'd1; pc = 32'h200;
        tick();
        idle();
        n = 0; got = 0;
        while (n < 200 && !got) begin
            tick(); n++;
            if (ifa.reset_lane_o[0]) got = 1;
        end
        chk("timeout_latency", 64'(n), 64'(T));
        chk("timeout_lane",    64'(ifa.reset_lane_idx_o[0]), 64'd1);
        tick();
        chk("timeout_busy", 64'(ifa.lane_busy_o), 64'd0);

        // Flush of four pending lanes; the 2-slot instance drains over two cycles.
        do_reset();
        for (int l = 0; l < 4; l++) begin
            ins = 1; lane = 2'(l); pc = 32'h300 + 32'(l * 4);
            tick();
        end
        idle(); flush = 1;
        tick();
        flush = 0;
        chk("flush_a_ev",  64'(ifa.reset_lane_o), 64'h00F);
        chk("flush_a_idx", 64'(ifa.reset_lane_idx_o), 64'h000E4);
        chk("flush_b_ev",  64'(ifb.reset_lane_o), 64'h3);
        chk("flush_b_idx", 64'(ifb.reset_lane_idx_o), 64'h4);
        tick();
        chk("drain_b_ev",  64'(ifb.reset_lane_o), 64'h3);
        chk("drain_b_idx", 64'(ifb.reset_lane_idx_o), 64'hE);
        chk("drain_a_busy", 64'(ifa.lane_busy_o), 64'd0);
        chk("drain_b_busy", 64'(ifb.lane_busy_o), 64'hC);
        tick();
        chk("drained_b_busy", 64'(ifb.lane_busy_o), 64'd0);

        // Re-grant of a lane in the same cycle it is released.
        do_reset();
        ins = 1; lane = 2'd2; pc = 32'h500;
        tick();
        idle(); flush = 1;
        tick();
        chk("rel_ev",   64'(ifa.reset_lane_o), 64'h001);
        chk("rel_lane", 64'(ifa.reset_lane_idx_o[0]), 64'd2);
        idle(); ins = 1; lane = 2'd2; pc = 32'h504;
        tick();
        idle();
        chk("regrant_busy", 64'(ifa.lane_busy_o), 64'h4);
        chk("regrant_ovf",  64'(ifa.overflow_cnt_o), 64'd0);
        chk("regrant_ev",   64'(ifa.reset_lane_o), 64'd0);
        cv = 2'b01; cpc[0] = 32'h504;
        tick();
        idle();
        n = 0; got = 0;
        while (n < 200 && !got) begin
            tick(); n++;
            if (ifa.reset_lane_o[0]) got = 1;
        end
        chk("regrant_window", 64'(n), 64'(W));

        // Grant to an ACTIVE lane is dropped; async reset clears outputs at once.
        do_reset();
        ins = 1; lane = 2'd3; pc = 32'h600;
        tick();
        idle(); cv = 2'b10; cpc[1] = 32'h600;
        tick();
        idle(); ins = 1; lane = 2'd3; pc = 32'h604;
        tick();
        idle();
        chk("drop_ovf_a", 64'(ifa.overflow_cnt_o), 64'd1);
        chk("drop_ovf_b", 64'(ifb.overflow_cnt_o), 64'd1);
        tick();
        chk("active_busy", 64'(ifa.lane_busy_o), 64'h8);
        #2 rst_n = 0;
        #1;
        chk("async_busy", 64'(ifa.lane_busy_o), 64'd0);
        chk("async_ovf",  64'(ifa.overflow_cnt_o), 64'd0);
        chk("async_ev",   64'(ifa.reset_lane_o), 64'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ins    = ($urandom_range(2) == 0);
            lane   = 2'($urandom_range(3));
            pc     = 32'h1000 + 32'($urandom_range(3) * 4);
            flush  = ($urandom_range(39) == 0);
            cv[0]  = ($urandom_range(5) == 0);
            cv[1]  = ($urandom_range(5) == 0);
            cpc[0] = 32'h1000 + 32'($urandom_range(3) * 4);
            cpc[1] = 32'h1000 + 32'($urandom_range(3) * 4);
            tick();
            cmp_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
